// File: rtl/fsm_frame_tx.sv
// fsm_frame_tx
// Two-wire serial frame transmitter feeding the (a, b) line pair of the
// multi-segment receive FSM. One DATA_W-bit word is accepted per
// valid/ready handshake. Each word is sent as:
//   START  (a=1, b=1)            1 cycle
//   DATA   (a=1, b=bit, LSB 1st) DATA_W cycles
//   PARITY (a=1, b=even parity)  1 cycle, done=1
//   GAP    (a=0, b=0)            GAP_CYCLES cycles
//
// Ports:
//   clk       clock, all state on the rising edge
//   reset     asynchronous, active-high reset
//   tx_data   payload word, sampled only on the handshake
//   tx_valid  producer has a word
//   tx_ready  block can accept a word this cycle (IDLE and not in reset)
//   a         line strobe / frame-active
//   b         line data / start marker
//   busy      frame in progress (any state other than IDLE)
//   done      one-cycle pulse during the parity cycle
module fsm_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  // The gap counter is loaded with "remaining cycles after this one".
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t            state_reg,   state_next;
  logic [DATA_W-1:0] shift_reg,   shift_next;
  logic              parity_reg,  parity_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;

  // Ready is held low while reset is asserted so no word can be taken
  // by an edge that happens to coincide with reset release.
  assign tx_ready = (state_reg == IDLE) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      bit_cnt_reg <= bit_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  // Line outputs depend only on registered state, so nothing on the
  // producer side can glitch a or b.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    a            = 1'b0;
    b            = 1'b0;
    done         = 1'b0;
    busy         = 1'b1;

    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (tx_valid && tx_ready) begin
          shift_next   = tx_data;
          parity_next  = ^tx_data;
          bit_cnt_next = '0;
          state_next   = START;
        end
      end

      START: begin
        a            = 1'b1;
        b            = 1'b1;
        bit_cnt_next = '0;
        state_next   = DATA;
      end

      DATA: begin
        a            = 1'b1;
        b            = shift_reg[0];
        shift_next   = shift_reg >> 1;
        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
        if (bit_cnt_reg == LAST_BIT) begin
          state_next = PARITY;
        end
      end

      PARITY: begin
        a    = 1'b1;
        b    = parity_reg;
        done = 1'b1;
        if (GAP_CYCLES > 0) begin
          gap_cnt_next = GAP_LOAD;
          state_next   = GAP;
        end else begin
          state_next = IDLE;
        end
      end

      GAP: begin
        if (gap_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end

      // Unused encodings recover to IDLE with the line quiet.
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
